// File: rtl/audio_fir_decim.sv
// Decimating low-pass FIR between two show-ahead FIFOs: pops DECIM samples, then runs one tap per cycle.
// Output is written NUM_TAPS+1 cycles after the last pop; it stalls in S_OUT while out_full. Define AUDIO_FIR_DECIM_SAT_EN to saturate.
module audio_fir_decim #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_TAPS   = 32,
   parameter int DECIM      = 8,
   parameter int BITS       = 10,
   parameter logic [NUM_TAPS*DATA_WIDTH-1:0] COEFFS = {NUM_TAPS{DATA_WIDTH'(32)}}
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  out_full,
   output logic                  out_wr_en
);

   localparam int TAP_W = $clog2(NUM_TAPS);
   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   typedef enum logic [1:0] {S_FILL, S_MAC, S_OUT} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   x_q [NUM_TAPS];
   logic [DATA_WIDTH-1:0]   x_d [NUM_TAPS];
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TAP_W-1:0]        tap_q, tap_d;

   logic [DATA_WIDTH-1:0]   coef_tab [NUM_TAPS];
   logic [DATA_WIDTH-1:0]   coef, samp;
   logic signed [2*DATA_WIDTH-1:0] coef_w, samp_w, prod, prod_sh;
   logic [DATA_WIDTH-1:0]   q, acc_sum;

   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_coef
      assign coef_tab[k] = COEFFS[k*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef AUDIO_FIR_DECIM_SAT_EN
   localparam logic signed [2*DATA_WIDTH-1:0] Q_MAX_W = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [2*DATA_WIDTH-1:0] Q_MIN_W = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   logic [DATA_WIDTH:0] sum_w;
`endif

   // Product is formed at full double width so the arithmetic shift floors correctly.
   always_comb begin
      coef    = coef_tab[tap_q];
      samp    = x_q[tap_q];
      coef_w  = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef};
      samp_w  = {{DATA_WIDTH{samp[DATA_WIDTH-1]}}, samp};
      prod    = coef_w * samp_w;
      prod_sh = prod >>> BITS;
`ifdef AUDIO_FIR_DECIM_SAT_EN
      if (prod_sh > Q_MAX_W)      q = D_MAX;
      else if (prod_sh < Q_MIN_W) q = D_MIN;
      else                        q = DATA_WIDTH'(prod_sh);
      sum_w = {acc_q[DATA_WIDTH-1], acc_q} + {q[DATA_WIDTH-1], q};
      if (sum_w[DATA_WIDTH] != sum_w[DATA_WIDTH-1])
         acc_sum = sum_w[DATA_WIDTH] ? D_MIN : D_MAX;
      else
         acc_sum = sum_w[DATA_WIDTH-1:0];
`else
      q       = DATA_WIDTH'(prod_sh);
      acc_sum = acc_q + q;
`endif
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      acc_d     = acc_q;
      dout_d    = dout_q;
      cnt_d     = cnt_q;
      tap_d     = tap_q;
      in_rd_en  = (state_q == S_FILL) && !in_empty && !reset;
      out_wr_en = (state_q == S_OUT) && !out_full && !reset;
      case (state_q)
         S_FILL: begin
            if (in_rd_en) begin
               for (int k = NUM_TAPS-1; k > 0; k--) x_d[k] = x_q[k-1];
               x_d[0] = din;
               if (cnt_q == CNT_W'(DECIM-1)) begin
                  cnt_d   = '0;
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = S_MAC;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_MAC: begin
            acc_d = acc_sum;
            tap_d = tap_q + TAP_W'(1);
            if (tap_q == TAP_W'(NUM_TAPS-1)) begin
               tap_d   = '0;
               dout_d  = acc_sum;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (out_wr_en) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FILL;
         for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
         acc_q   <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         tap_q   <= tap_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_audio_fir_decim.sv
// Scoreboard bench for audio_fir_decim: 4 taps {1,2,3,4}, decimate by 2, FIFOs modelled by queues.
module tb_audio_fir_decim;
   localparam int DW = 32;
   localparam int NT = 4;
   localparam int DC = 2;
   localparam logic [NT*DW-1:0] CO = {32'd4096, 32'd3072, 32'd2048, 32'd1024};

   logic          clock;
   logic          reset;
   logic [DW-1:0] din;
   logic          in_empty;
   logic          in_rd_en;
   logic [DW-1:0] dout;
   logic          out_full;
   logic          out_wr_en;

   audio_fir_decim #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .DECIM(DC), .BITS(10), .COEFFS(CO)) dut (
      .clock(clock), .reset(reset), .din(din), .in_empty(in_empty), .in_rd_en(in_rd_en),
      .dout(dout), .out_full(out_full), .out_wr_en(out_wr_en)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gap_len = 0;
   int gap_cnt = 0;
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] exp_q[$];
   int pop_cyc[$];
   int wr_cyc[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Input FIFO model: show-ahead, optional empty gap after every pop.
   initial begin : drv
      logic popped;
      forever begin
         @(negedge clock);
         popped = in_rd_en;
         if (in_empty) check("rd_while_empty", DW'(in_rd_en), '0);
         if (popped) pop_cyc.push_back(cyc + 1);
         @(posedge clock);
         #1;
         if (popped && in_q.size() > 0) begin
            void'(in_q.pop_front());
            gap_cnt = gap_len;
         end
         if (in_q.size() == 0 || gap_cnt > 0) begin
            in_empty = 1'b1;
            if (gap_cnt > 0) gap_cnt--;
         end else begin
            in_empty = 1'b0;
            din      = in_q[0];
         end
      end
   end

   initial begin : mon
      forever begin
         @(negedge clock);
         if (out_wr_en) begin
            wr_cyc.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: dout=%h with no expected output", dout);
            end else begin
               check("dout", dout, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_q.delete();
      in_q.push_back(32'h0000_1234);
      tick(1);
      @(negedge clock);
      check("rst_rd_en", DW'(in_rd_en), '0);
      check("rst_wr_en", DW'(out_wr_en), '0);
      check("rst_dout", dout, '0);
      in_q.delete();
      tick(1);
      reset   = 1'b0;
      gap_len = 0;
      gap_cnt = 0;
      pop_cyc.delete();
      wr_cyc.delete();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() > 0 || in_q.size() > 0) && n < 400) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL %s_timeout: %0d outputs still pending, expected 0", name, exp_q.size());
         exp_q.delete();
         in_q.delete();
      end
      tick(NT + DC + 3);
   endtask

   task automatic push_n(input logic [DW-1:0] v, input int n);
      repeat (n) in_q.push_back(v);
   endtask

   initial begin : main
      int n;
      reset    = 1'b1;
      in_empty = 1'b1;
      din      = '0;
      out_full = 1'b0;
      tick(1);

      // Impulse
      do_reset();
      in_q.push_back(32'd1);
      push_n(32'd0, 5);
      exp_q.push_back(32'd2);
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd0);
      wait_idle("impulse");
      check("write_count", DW'(wr_cyc.size()), 32'd3);
      if (pop_cyc.size() >= 2 && wr_cyc.size() >= 1)
         check("latency", DW'(wr_cyc[0] - pop_cyc[1]), 32'd5);
      else
         check("latency_events", DW'(pop_cyc.size() + wr_cyc.size()), 32'd9);

      // Constant
      do_reset();
      push_n(32'd5, 8);
      exp_q.push_back(32'd15);
      push_n(32'd0, 0);
      repeat (3) exp_q.push_back(32'd50);
      wait_idle("constant");

      // Backpressure
      do_reset();
      out_full = 1'b1;
      push_n(32'd5, 8);
      exp_q.push_back(32'd15);
      repeat (3) exp_q.push_back(32'd50);
      tick(7);
      check("stall_in_q", DW'(in_q.size()), 32'd6);
      repeat (20) begin
         @(negedge clock);
         check("stall_wr_en", DW'(out_wr_en), '0);
         check("stall_rd_en", DW'(in_rd_en), '0);
         check("stall_dout", dout, 32'd15);
         tick(1);
      end
      out_full = 1'b0;
      @(negedge clock);
      check("release_wr_en", DW'(out_wr_en), 32'd1);
      tick(1);
      @(negedge clock);
      check("single_write", DW'(out_wr_en), '0);
      wait_idle("backpressure");

      // Starvation
      do_reset();
      gap_len = 3;
      push_n(32'd5, 8);
      exp_q.push_back(32'd15);
      repeat (3) exp_q.push_back(32'd50);
      wait_idle("starvation");
      gap_len = 0;

      // Overflow
      do_reset();
      push_n(32'h7FFF_FFFF, 2);
`ifdef AUDIO_FIR_DECIM_SAT_EN
      exp_q.push_back(32'h7FFF_FFFF);
`else
      exp_q.push_back(32'h7FFF_FFFD);
`endif
      wait_idle("overflow_pos");
      do_reset();
      push_n(32'h8000_0000, 2);
      exp_q.push_back(32'h8000_0000);
      wait_idle("overflow_neg");

      // Reset during MAC
      do_reset();
      in_q.push_back(32'd1);
      in_q.push_back(32'd0);
      n = 0;
      while (pop_cyc.size() < 2 && n < 50) begin
         tick(1);
         n++;
      end
      check("abort_pops", DW'(pop_cyc.size()), 32'd2);
      tick(2);
      reset = 1'b1;
      tick(1);
      @(negedge clock);
      check("abort_wr_en", DW'(out_wr_en), '0);
      check("abort_rd_en", DW'(in_rd_en), '0);
      check("abort_dout", dout, '0);
      tick(1);
      reset = 1'b0;
      tick(NT + DC + 4);
      check("abort_no_write", DW'(wr_cyc.size()), '0);
      in_q.push_back(32'd1);
      in_q.push_back(32'd0);
      exp_q.push_back(32'd2);
      wait_idle("after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
